// File: rtl/calc_pkg.sv
// calc_pkg: shared command/response codes, request record and capture-FSM
// state type for the multi-port calculator engine.
package calc_pkg;

  // Command codes carried on cmd_in; any other nonzero code is invalid.
  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  // Response codes driven on out_resp; code 3 is never produced.
  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  // Default operand and tag widths of the engine.
  localparam int CALC_DATA_W = 32;
  localparam int CALC_TAG_W  = 2;

  // Request record at the default widths: {cmd, op1, op2, tag}.
  typedef struct packed {
    logic [3:0]             cmd;
    logic [CALC_DATA_W-1:0] op1;
    logic [CALC_DATA_W-1:0] op2;
    logic [CALC_TAG_W-1:0]  tag;
  } calc_req_t;

  // Per-port capture FSM: IDLE waits for a command, OP2 takes the second operand.
  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_OP2  = 1'b1
  } cap_state_e;

endpackage

// File: rtl/calc_req_fifo.sv
// calc_req_fifo: synchronous FIFO with registered full flag. A push while
// full is accepted only when a pop happens on the same edge; the caller is
// responsible for noticing a rejected push.
module calc_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             full_q;
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok  = pop_i && (cnt_q != '0);
  assign push_ok = push_i && (!full_q || pop_ok);

  // Occupancy after this edge; simultaneous push and pop leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers, count and the registered full flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == CW'(DEPTH));
    end
  end

  // Storage; when full with a same-edge pop the write reuses the slot being read.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/calc_mp_engine.sv
// calc_mp_engine: NUM_PORTS two-cycle command ports, each feeding its own
// request FIFO, round-robin arbitrated onto one ALU_LAT-stage ALU pipeline.
// Results return on the originating port for one cycle with the request tag.
// Optional feature macro: CALC_SHIFT_EN (commands 5/6 execute as logical
// shifts; without it they are treated as invalid and no shifter is built).
module calc_mp_engine
  import calc_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = CALC_DATA_W,
  parameter int TAG_W     = CALC_TAG_W,
  parameter int QDEPTH    = 4,
  parameter int ALU_LAT   = 2
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*4-1:0]      cmd_in,
  input  logic [NUM_PORTS*DATA_W-1:0] data_in,
  input  logic [NUM_PORTS*TAG_W-1:0]  tag_in,
  output logic [NUM_PORTS-1:0]        port_full,
  output logic [NUM_PORTS*2-1:0]      out_resp,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  output logic [NUM_PORTS*TAG_W-1:0]  out_tag,
  output logic [NUM_PORTS-1:0]        drop_err
);

  localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  // Same field order as calc_req_t, sized by this instance's parameters.
  typedef struct packed {
    logic [3:0]        cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [TAG_W-1:0]  tag;
  } req_t;
  localparam int REQ_W = $bits(req_t);

  // Capture FSM state (observable per port) and latched first-cycle fields.
  cap_state_e        cap_state_q [NUM_PORTS];
  cap_state_e        cap_state_d [NUM_PORTS];
  logic [3:0]        cap_cmd_q   [NUM_PORTS];
  logic [DATA_W-1:0] cap_op1_q   [NUM_PORTS];
  logic [TAG_W-1:0]  cap_tag_q   [NUM_PORTS];

  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;
  logic [NUM_PORTS-1:0] fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  req_t                 push_req [NUM_PORTS];
  req_t                 head_req [NUM_PORTS];

  logic [PW-1:0]        rr_q;
  logic                 gnt_vld;
  logic [PW-1:0]        gnt_idx;
  logic [PW-1:0]        cand;
  req_t                 gnt_req;

  logic [DATA_W:0]      alu_sum;
  logic [1:0]           alu_resp;
  logic [DATA_W-1:0]    alu_data;

  logic [ALU_LAT-1:0]   pipe_vld_q;
  logic [PW-1:0]        pipe_port_q [ALU_LAT];
  logic [1:0]           pipe_resp_q [ALU_LAT];
  logic [DATA_W-1:0]    pipe_data_q [ALU_LAT];
  logic [TAG_W-1:0]     pipe_tag_q  [ALU_LAT];

  logic [NUM_PORTS-1:0] drop_err_q;

  // Capture FSM next state; the OP2 cycle pushes the assembled request.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      cap_state_d[p] = cap_state_q[p];
      push[p]        = 1'b0;
      case (cap_state_q[p])
        CAP_IDLE: if (cmd_in[4*p +: 4] != CMD_NOP) cap_state_d[p] = CAP_OP2;
        CAP_OP2: begin
          cap_state_d[p] = CAP_IDLE;
          push[p]        = 1'b1;
        end
        default: cap_state_d[p] = CAP_IDLE;
      endcase
      push_req[p] = '{cmd: cap_cmd_q[p], op1: cap_op1_q[p],
                      op2: data_in[DATA_W*p +: DATA_W], tag: cap_tag_q[p]};
    end
  end

  // Capture FSM state register.
  always_ff @(posedge c_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (reset) cap_state_q[p] <= CAP_IDLE;
      else       cap_state_q[p] <= cap_state_d[p];
    end
  end

  // Latch cmd, op1 and tag on the first cycle of a request.
  always_ff @(posedge c_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (cap_state_q[p] == CAP_IDLE && cmd_in[4*p +: 4] != CMD_NOP) begin
        cap_cmd_q[p] <= cmd_in[4*p +: 4];
        cap_op1_q[p] <= data_in[DATA_W*p +: DATA_W];
        cap_tag_q[p] <= tag_in[TAG_W*p +: TAG_W];
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    calc_req_fifo #(
      .DEPTH (QDEPTH),
      .WIDTH (REQ_W)
    ) u_fifo (
      .clk_i   (c_clk),
      .rst_i   (reset),
      .push_i  (push[g]),
      .wdata_i (push_req[g]),
      .pop_i   (pop[g]),
      .rdata_o (head_req[g]),
      .full_o  (fifo_full[g]),
      .empty_o (fifo_empty[g])
    );
  end

  // Round-robin pick: first non-empty FIFO after the last granted port.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = rr_q;
    cand    = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = PW'((int'(rr_q) + k) % NUM_PORTS);
      if (!gnt_vld && !fifo_empty[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    pop = '0;
    if (gnt_vld) pop[gnt_idx] = 1'b1;
  end

  // Arbiter pointer moves only when something was granted.
  always_ff @(posedge c_clk) begin
    if (reset)        rr_q <= PW'(NUM_PORTS - 1);
    else if (gnt_vld) rr_q <= gnt_idx;
  end

  assign gnt_req = head_req[gnt_idx];

  // Unsigned ALU; errors (carry, borrow, invalid code) return zero data.
  always_comb begin
    alu_resp = RESP_ERR;
    alu_data = '0;
    alu_sum  = {1'b0, gnt_req.op1} + {1'b0, gnt_req.op2};
    case (gnt_req.cmd)
      CMD_ADD: begin
        if (!alu_sum[DATA_W]) begin
          alu_resp = RESP_OK;
          alu_data = alu_sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (gnt_req.op2 <= gnt_req.op1) begin
          alu_resp = RESP_OK;
          alu_data = gnt_req.op1 - gnt_req.op2;
        end
      end
`ifdef CALC_SHIFT_EN
      CMD_SHL: begin
        alu_resp = RESP_OK;
        alu_data = gnt_req.op1 << gnt_req.op2[SH_W-1:0];
      end
      CMD_SHR: begin
        alu_resp = RESP_OK;
        alu_data = gnt_req.op1 >> gnt_req.op2[SH_W-1:0];
      end
`endif
      default: ;
    endcase
  end

  // Pipeline valids; reset discards everything in flight.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= gnt_vld;
      for (int i = 1; i < ALU_LAT; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
    end
  end

  // Pipeline payload: result, tag and destination port travel together.
  always_ff @(posedge c_clk) begin
    pipe_port_q[0] <= gnt_idx;
    pipe_resp_q[0] <= alu_resp;
    pipe_data_q[0] <= alu_data;
    pipe_tag_q[0]  <= gnt_req.tag;
    for (int i = 1; i < ALU_LAT; i++) begin
      pipe_port_q[i] <= pipe_port_q[i-1];
      pipe_resp_q[i] <= pipe_resp_q[i-1];
      pipe_data_q[i] <= pipe_data_q[i-1];
      pipe_tag_q[i]  <= pipe_tag_q[i-1];
    end
  end

  // Output demux: only the destination port sees the result, all else zero.
  always_comb begin
    out_resp = '0;
    out_data = '0;
    out_tag  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (pipe_vld_q[ALU_LAT-1] && pipe_port_q[ALU_LAT-1] == PW'(p)) begin
        out_resp[2*p +: 2]           = pipe_resp_q[ALU_LAT-1];
        out_data[DATA_W*p +: DATA_W] = pipe_data_q[ALU_LAT-1];
        out_tag[TAG_W*p +: TAG_W]    = pipe_tag_q[ALU_LAT-1];
      end
    end
  end

  // Sticky drop flag: a push refused because the FIFO was full with no pop.
  always_ff @(posedge c_clk) begin
    if (reset) drop_err_q <= '0;
    else       drop_err_q <= drop_err_q | (push & fifo_full & ~pop);
  end

  assign drop_err  = drop_err_q;
  assign port_full = fifo_full;

endmodule
